hoaa_pipe_adder: RTL and testbench
==================================

Name: hoaa_pipe_adder

Overview:
- N-bit hybrid approximate adder built around the registered 1-bit lower-part OR cell.
- Lower APPROX_BITS bits are approximated as a|b, with no carry chain. Upper bits are added exactly, using a carry-in predicted from the MSB of the lower part.
- Two-stage pipeline with valid/ready handshakes on both sides, for use in approximate datapaths (filters, MAC accumulators).
- Optional on-line error monitor compares each result against the exact sum.

Parameters:
- WIDTH, 16, operand and sum width; legal range 2..32.
- APPROX_BITS, 4, number of OR-approximated low bits (k); legal range 0..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  approximate sum
- cout  output  1  approximate carry-out
- err_count  output  32  number of results that differed from the exact sum (monitor only)
- err_abs_acc  output  32  accumulated absolute error distance (monitor only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, sum=0, cout=0, stage-1 valid=0, err_count=0, err_abs_acc=0. in_ready reads 1 in the cycle after reset.
- Reset mid-operation: discards all in-flight data. No result from before the reset is ever presented.
- Stage 1 captures on in_valid && in_ready:
  - lo = a[k-1:0] | b[k-1:0]
  - ch = a[k-1] & b[k-1] (ch=0 when k=0)
  - a_hi = a[WIDTH-1:k], b_hi = b[WIDTH-1:k]
- Stage 2:
  - {cout, hi} = a_hi + b_hi + ch, with WIDTH-k+1 bit arithmetic.
  - sum = {hi, lo}.
  - k=WIDTH: no upper part; sum = a|b, cout = ch.
  - k=0: fully exact adder.
- Latency: 2 cycles from accepted input to out_valid when out_ready is held high. Throughput: 1 result per cycle.
- Elastic pipeline rules:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid || s2_load. in_ready is a function of register state and out_ready only, never of in_valid.
- Back-pressure: while out_valid && !out_ready, sum and cout hold stable. No result is dropped or duplicated. At most 2 results are buffered internally.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- Overflow: the upper-part sum wraps modulo 2^(WIDTH-k); the overflow appears only on cout.

Optional Feature:
- Macro: HOAA_ERR_MONITOR_EN.
- Defined:
  - Stage 1 also registers the exact sum E = a + b (WIDTH+1 bits).
  - On every output handshake (out_valid && out_ready), the block compares approx A = {cout, sum} against E.
  - If A != E: err_count increments by 1 and err_abs_acc increments by |A-E|.
  - Both counters saturate at 0xFFFFFFFF and never wrap.
  - Counters update only on handshake; results stalled by back-pressure are counted once.
- Not defined: no exact-sum registers are built, and err_count and err_abs_acc are tied to 0.

Test Plan:
- Reset behaviour: assert rst for 2 cycles mid-stream with 2 results in flight -> out_valid=0 and both counters 0 the next cycle; the in-flight results never appear.
- Basic sums (WIDTH=8, k=4, out_ready=1):
  - a=0x3C, b=0x25 -> sum=0x5D, cout=0, 2 cycles later.
  - With monitor: err_count=1, err_abs_acc=4.
- Carry-hint case:
  - a=0x88, b=0x88 -> sum=0x18, cout=1 (exact result 0x110).
  - With monitor: err_abs_acc increments by 8.
- Lower-part carry loss:
  - a=0xFF, b=0x01 -> sum=0xFF, cout=0.
  - With monitor: err_abs_acc increments by 1.
  - Exact case a=0x10, b=0x20 -> sum=0x30 with no counter change.
- Back-pressure: stream 6 random pairs with out_ready toggled pseudo-randomly -> results arrive in order and match the reference model; sum is stable while stalled; in_ready=0 only when both stages are full and out_ready=0.
- Parameter corners:
  - k=0 -> random vectors match a+b exactly; err_count stays 0.
  - k=WIDTH, a=0x80, b=0x80 -> sum=0x80, cout=1.

Source files
------------

// File: rtl/hoaa_pipe_adder.sv
// Two-stage elastic approximate adder: low APPROX_BITS bits are OR-approximated, upper bits exact with a predicted carry.
// Optional exact-sum error monitor is built when HOAA_ERR_MONITOR_EN is defined.
module hoaa_pipe_adder #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [31:0]      err_count,
    output logic [31:0]      err_abs_acc
);

    localparam int CH_IDX = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
    localparam logic [WIDTH-1:0] LO_MASK =
        (APPROX_BITS == 0) ? {WIDTH{1'b0}} : ({WIDTH{1'b1}} >> (WIDTH - APPROX_BITS));

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] ahi_q, ahi_d;
    logic [WIDTH-1:0] bhi_q, bhi_d;
    logic             ch_q, ch_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH:0]   hi_sum;

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        lo_d       = lo_q;
        ahi_d      = ahi_q;
        bhi_d      = bhi_q;
        ch_d       = ch_q;
        if (s2_load) begin
            s1_valid_d = s1_load;
        end
        if (s1_load) begin
            lo_d  = (a | b) & LO_MASK;
            ahi_d = a >> APPROX_BITS;
            bhi_d = b >> APPROX_BITS;
            ch_d  = (APPROX_BITS > 0) ? (a[CH_IDX] & b[CH_IDX]) : 1'b0;
        end
    end

    // Upper part is aligned to bit 0 so the carry-out lands at bit WIDTH-k for every k, including k=WIDTH.
    always_comb begin
        hi_sum      = {1'b0, ahi_q} + {1'b0, bhi_q} + {{WIDTH{1'b0}}, ch_q};
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = WIDTH'(hi_sum << APPROX_BITS) | lo_q;
                cout_d = hi_sum[WIDTH-APPROX_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            lo_q        <= '0;
            ahi_q       <= '0;
            bhi_q       <= '0;
            ch_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_q        <= lo_d;
            ahi_q       <= ahi_d;
            bhi_q       <= bhi_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef HOAA_ERR_MONITOR_EN
    logic [WIDTH:0] exact1_q, exact1_d;
    logic [WIDTH:0] exact2_q, exact2_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [31:0]    acc_q, acc_d;
    logic [WIDTH:0] approx_v;
    logic [WIDTH:0] dist;
    logic [33:0]    acc_sum;

    always_comb begin
        exact1_d = exact1_q;
        exact2_d = exact2_q;
        if (s1_load) begin
            exact1_d = {1'b0, a} + {1'b0, b};
        end
        if (s2_load && s1_valid_q) begin
            exact2_d = exact1_q;
        end
    end

    // Counters move only on the output handshake, so a stalled result is counted exactly once.
    always_comb begin
        approx_v = {cout_q, sum_q};
        dist     = (approx_v >= exact2_q) ? (approx_v - exact2_q) : (exact2_q - approx_v);
        acc_sum  = {2'b00, acc_q} + {{(33 - WIDTH){1'b0}}, dist};
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        if (out_valid_q && out_ready && (approx_v != exact2_q)) begin
            cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
            acc_d = (acc_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : acc_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exact1_q <= '0;
            exact2_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            exact1_q <= exact1_d;
            exact2_q <= exact2_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end

    assign err_count   = cnt_q;
    assign err_abs_acc = acc_q;
`else
    assign err_count   = 32'd0;
    assign err_abs_acc = 32'd0;
`endif

endmodule

// File: tb/tb_hoaa_pipe_adder.sv
// Directed bench for hoaa_pipe_adder: WIDTH=8 with k=4 (main), k=0 (exact) and k=8 (all-OR) instances sharing stimulus.
module tb_hoaa_pipe_adder;

`ifdef HOAA_ERR_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;

    logic       in_ready,  out_valid,  cout;
    logic [7:0] sum;
    logic [31:0] err_count, err_abs_acc;
    logic       ex_in_ready, ex_out_valid, ex_cout;
    logic [7:0] ex_sum;
    logic [31:0] ex_err_count, ex_err_abs_acc;
    logic       or_in_ready, or_out_valid, or_cout;
    logic [7:0] or_sum;
    logic [31:0] or_err_count, or_err_abs_acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hoaa_pipe_adder #(.WIDTH(8), .APPROX_BITS(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .err_count(err_count), .err_abs_acc(err_abs_acc)
    );

    hoaa_pipe_adder #(.WIDTH(8), .APPROX_BITS(0)) u_ex (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ex_in_ready), .a(a), .b(b),
        .out_valid(ex_out_valid), .out_ready(out_ready), .sum(ex_sum), .cout(ex_cout),
        .err_count(ex_err_count), .err_abs_acc(ex_err_abs_acc)
    );

    hoaa_pipe_adder #(.WIDTH(8), .APPROX_BITS(8)) u_or (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(or_in_ready), .a(a), .b(b),
        .out_valid(or_out_valid), .out_ready(out_ready), .sum(or_sum), .cout(or_cout),
        .err_count(or_err_count), .err_abs_acc(or_err_abs_acc)
    );

    task automatic checkOutput(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one operand pair into an idle pipe and leaves it two edges later with the result presented.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    function automatic logic [8:0] approxRef(input logic [7:0] x, input logic [7:0] y);
        logic [4:0] hi;
        logic [3:0] lo;
        lo = x[3:0] | y[3:0];
        hi = {1'b0, x[7:4]} + {1'b0, y[7:4]} + {4'b0000, (x[3] & y[3])};
        return {hi, lo};
    endfunction

    logic [17:0] expQ[$];
    logic [31:0] pat;
    logic [7:0]  va, vb;
    logic        seen, acc, emit, expIr;
    int          sent, got, cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_cout", cout, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_err_abs", err_abs_acc, 0);

        applyStimulus(8'h3C, 8'h25);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_main", {cout, sum}, 9'h05D);
        checkOutput("t1_exact", {ex_cout, ex_sum}, 9'h061);
        checkOutput("t1_or", {or_cout, or_sum}, 9'h03D);
        tick();
        checkOutput("t1_drained", out_valid, 0);
        checkOutput("t1_err_count", err_count, MON ? 1 : 0);
        checkOutput("t1_err_abs", err_abs_acc, MON ? 4 : 0);

        applyStimulus(8'h88, 8'h88);
        checkOutput("t2_main", {cout, sum}, 9'h118);
        checkOutput("t2_exact", {ex_cout, ex_sum}, 9'h110);
        checkOutput("t2_or", {or_cout, or_sum}, 9'h188);
        tick();
        checkOutput("t2_err_count", err_count, MON ? 2 : 0);
        checkOutput("t2_err_abs", err_abs_acc, MON ? 12 : 0);

        applyStimulus(8'hFF, 8'h01);
        checkOutput("t3_main", {cout, sum}, 9'h0FF);
        checkOutput("t3_exact", {ex_cout, ex_sum}, 9'h100);
        checkOutput("t3_or", {or_cout, or_sum}, 9'h0FF);
        tick();
        checkOutput("t3_err_count", err_count, MON ? 3 : 0);
        checkOutput("t3_err_abs", err_abs_acc, MON ? 13 : 0);

        applyStimulus(8'h10, 8'h20);
        checkOutput("t4_main", {cout, sum}, 9'h030);
        checkOutput("t4_or", {or_cout, or_sum}, 9'h030);
        tick();
        checkOutput("t4_err_count", err_count, MON ? 3 : 0);
        checkOutput("t4_err_abs", err_abs_acc, MON ? 13 : 0);

        applyStimulus(8'h80, 8'h80);
        checkOutput("t5_main", {cout, sum}, 9'h100);
        checkOutput("t5_exact", {ex_cout, ex_sum}, 9'h100);
        checkOutput("t5_or", {or_cout, or_sum}, 9'h180);
        tick();

        // Fill both stages under stall, then reset: neither buffered result may ever appear.
        out_ready = 1'b0;
        a = 8'h01; b = 8'h01; in_valid = 1'b1;
        tick();
        a = 8'h02; b = 8'h02;
        tick();
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_out_valid", out_valid, 1);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_err_count", err_count, 0);
        checkOutput("mid_rst_err_abs", err_abs_acc, 0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | out_valid;
        end
        checkOutput("mid_rst_no_ghost", seen, 0);

        pat  = 32'b1011_0010_1101_0011_0100_1110_0010_1011;
        sent = 0;
        got  = 0;
        cyc  = 0;
        va   = 8'($urandom_range(0, 255));
        vb   = 8'($urandom_range(0, 255));
        while (got < 6 && cyc < 200) begin
            out_ready = pat[cyc % 32];
            in_valid  = (sent < 6);
            a = va;
            b = vb;
            #1;
            expIr = !(expQ.size() == 2 && !out_ready);
            checkOutput("bp_in_ready", in_ready, expIr);
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (out_valid) begin
                if (expQ.size() > 0) begin
                    checkOutput("bp_main", {cout, sum}, expQ[0][17:9]);
                    checkOutput("bp_exact", {ex_cout, ex_sum}, expQ[0][8:0]);
                end else begin
                    checkOutput("bp_spurious", out_valid, 0);
                end
            end
            if (emit && expQ.size() > 0) begin
                void'(expQ.pop_front());
                got++;
            end
            if (acc) begin
                expQ.push_back({approxRef(va, vb), {1'b0, va} + {1'b0, vb}});
                sent++;
                va = 8'($urandom_range(0, 255));
                vb = 8'($urandom_range(0, 255));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_all_received", got, 6);
        tick();
        checkOutput("exact_err_count", ex_err_count, 0);
        checkOutput("exact_err_abs", ex_err_abs_acc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
